// File: rtl/wr_fifo_w16r128_if.sv
// Handshake and status bundle for the 16-bit-in / 128-bit-out FIFO.
// The master side drives write data and the two requests.
// The slave side (the FIFO) returns read data, flags and water levels.
interface wr_fifo_w16r128_if #(
    parameter int WR_DEPTH_WIDTH = 13,
    parameter int WR_DATA_WIDTH  = 16,
    parameter int RD_DEPTH_WIDTH = 10,
    parameter int RD_DATA_WIDTH  = 128
) ();
    logic [WR_DATA_WIDTH-1:0]  wr_data;
    logic                      wr_en;
    logic                      wr_full;
    logic [WR_DEPTH_WIDTH:0]   wr_water_level;
    logic                      almost_full;
    logic [RD_DATA_WIDTH-1:0]  rd_data;
    logic                      rd_en;
    logic                      rd_empty;
    logic [RD_DEPTH_WIDTH:0]   rd_water_level;
    logic                      almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, wr_water_level, almost_full,
        input  rd_data, rd_empty, rd_water_level, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, wr_water_level, almost_full,
        output rd_data, rd_empty, rd_water_level, almost_empty
    );
endinterface

// File: rtl/wr_fifo_w16r128.sv
// Single-clock width-converting FIFO: 16-bit write words in, 128-bit read
// words out, each read word packing 8 consecutive write words LSB-first.
// Optional macro WR_FIFO_OUTPUT_REG_EN adds an output register after the
// memory read, giving a two-cycle read latency instead of one.
//
// Storage is 8192 x 16 bits, laid out as 1024 rows of 8 lanes so that a
// whole read word comes out of a single row. The write pointer counts write
// words (low bits select the lane, high bits the row); the read pointer
// counts rows. Occupancy is the pointer difference in write words, which
// fits in WR_DEPTH_WIDTH+1 bits for 0..8192.
module wr_fifo_w16r128 #(
    parameter int WR_DEPTH_WIDTH   = 13,
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RD_DEPTH_WIDTH   = 10,
    parameter int RD_DATA_WIDTH    = 128,
    parameter int ALMOST_FULL_NUM  = 252,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input logic               clk,
    input logic               rst,
    wr_fifo_w16r128_if.slave  bus
);
    localparam int LANE_BITS = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
    localparam int LANES     = 2 ** LANE_BITS;
    localparam int ROWS      = 2 ** RD_DEPTH_WIDTH;

    localparam logic [WR_DEPTH_WIDTH:0] CAPACITY = (WR_DEPTH_WIDTH + 1)'(2 ** WR_DEPTH_WIDTH);
    localparam logic [WR_DEPTH_WIDTH:0] AF_LEVEL = (WR_DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
    localparam logic [RD_DEPTH_WIDTH:0] AE_LEVEL = (RD_DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);
    localparam logic [WR_DEPTH_WIDTH:0] WR_STEP  = (WR_DEPTH_WIDTH + 1)'(1);
    localparam logic [RD_DEPTH_WIDTH:0] RD_STEP  = (RD_DEPTH_WIDTH + 1)'(1);

    logic [LANES-1:0][WR_DATA_WIDTH-1:0] mem [ROWS];

    logic [WR_DEPTH_WIDTH:0] wr_ptr;
    logic [RD_DEPTH_WIDTH:0] rd_ptr;
    logic [WR_DEPTH_WIDTH:0] wr_level;
    logic [RD_DEPTH_WIDTH:0] rd_level;
    logic                    full;
    logic                    empty;
    logic                    wr_accept;
    logic                    rd_accept;
    logic [RD_DATA_WIDTH-1:0] rd_word;

    // Occupancy and flags come straight from the registered pointers.
    assign wr_level  = wr_ptr - {rd_ptr, {LANE_BITS{1'b0}}};
    assign rd_level  = wr_level[WR_DEPTH_WIDTH:LANE_BITS];
    assign full      = (wr_level == CAPACITY);
    assign empty     = (rd_level == '0);
    assign wr_accept = bus.wr_en & ~full;
    assign rd_accept = bus.rd_en & ~empty;

    assign bus.wr_full        = full;
    assign bus.wr_water_level = wr_level;
    assign bus.almost_full    = (wr_level >= AF_LEVEL);
    assign bus.rd_empty       = empty;
    assign bus.rd_water_level = rd_level;
    assign bus.almost_empty   = (rd_level <= AE_LEVEL);

    // Write one 16-bit lane of the current row; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr[WR_DEPTH_WIDTH-1:LANE_BITS]][wr_ptr[LANE_BITS-1:0]] <= bus.wr_data;
        end
    end

    // Pointer advance; both wrap through their extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + WR_STEP;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + RD_STEP;
            end
        end
    end

    // Capture the popped row; holds its value while no read is accepted.
    // A row being read is always complete, so it never collides with the
    // row currently receiving writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word <= '0;
        end else if (rd_accept) begin
            rd_word <= mem[rd_ptr[RD_DEPTH_WIDTH-1:0]];
        end
    end

`ifdef WR_FIFO_OUTPUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] rd_pipe;

    // Extra output stage to relax timing from the wide memory read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= rd_word;
        end
    end

    assign bus.rd_data = rd_pipe;
`else
    assign bus.rd_data = rd_word;
`endif

endmodule

// File: tb/tb_wr_fifo_w16r128.sv
// Self-checking bench for wr_fifo_w16r128: a queue model of stored write
// words feeds a scoreboard of expected read words (due LAT cycles after the
// accepted read), a table of vectors covers partial groups and simultaneous
// access, and hand sequences cover fill/drain limits and mid-run reset.
module tb_wr_fifo_w16r128;
`ifdef WR_FIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wr_fifo_w16r128_if bus ();

    wr_fifo_w16r128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [127:0] word;
        int           due;
    } pend_t;

    typedef struct {
        logic        we;
        logic [15:0] wd;
        logic        re;
        logic [13:0] wl;
        logic [10:0] rl;
        logic        empty;
        logic        ae;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic [15:0]  m_q[$];
    pend_t        pend_q[$];
    logic [127:0] hold = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, update the model at the edge, check 1 ns later.
    task automatic step(input logic we, input logic [15:0] wd, input logic re, input logic r);
        logic [127:0] w;
        pend_t        p;
        logic         wacc;
        int           n;
        logic [28:0]  exp_st;
        logic [28:0]  act_st;
        rst         = r;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_q.delete();
            pend_q.delete();
            hold = '0;
        end else begin
            wacc = we && (m_q.size() < 8192);
            if (re && m_q.size() >= 8) begin
                for (int k = 0; k < 8; k++) w[k*16 +: 16] = m_q.pop_front();
                p.word = w;
                p.due  = cyc + LAT - 1;
                pend_q.push_back(p);
            end
            if (wacc) m_q.push_back(wd);
        end
        #1;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) hold = pend_q.pop_front().word;
        n = m_q.size();
        exp_st = {(n == 8192), (n >= 252), ((n / 8) == 0), ((n / 8) <= 4), 14'(n), 11'(n / 8)};
        act_st = {bus.wr_full, bus.almost_full, bus.rd_empty, bus.almost_empty,
                  bus.wr_water_level, bus.rd_water_level};
        chk("status", 128'(act_st), 128'(exp_st));
        chk("rd_data", bus.rd_data, hold);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_full"}, 128'(bus.wr_full), 128'(0));
        chk({tag, "_almost_full"}, 128'(bus.almost_full), 128'(0));
        chk({tag, "_rd_empty"}, 128'(bus.rd_empty), 128'(1));
        chk({tag, "_almost_empty"}, 128'(bus.almost_empty), 128'(1));
        chk({tag, "_wr_level"}, 128'(bus.wr_water_level), 128'(0));
        chk({tag, "_rd_level"}, 128'(bus.rd_water_level), 128'(0));
        chk({tag, "_rd_data"}, bus.rd_data, 128'(0));
    endtask

    vec_t         vecs[19];
    logic [15:0]  dval;
    logic [127:0] last;

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 16'h1000 + 16'(i), 1'b0, 14'(i + 1), 11'((i + 1) / 8),
                        ((i + 1) < 8), 1'b1};
        end
        vecs[16] = '{1'b1, 16'h2000, 1'b1, 14'd9, 11'd1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 16'h0000, 1'b1, 14'd1, 11'd0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 16'h0000, 1'b1, 14'd1, 11'd0, 1'b1, 1'b1};

        // Reset for 20 cycles, then one idle cycle.
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_reset_values("reset");

        // Fill with a down-counter, one write past capacity.
        dval = 16'hFFFF;
        for (int i = 1; i <= 8193; i++) begin
            step(1'b1, dval, 1'b0, 1'b0);
            dval = dval - 16'd1;
            if (i == 251) chk("af_before_252", 128'(bus.almost_full), 128'(0));
            if (i == 252) chk("af_at_252", 128'(bus.almost_full), 128'(1));
            if (i == 8192) begin
                chk("full_at_8192", 128'(bus.wr_full), 128'(1));
                chk("wl_at_8192", 128'(bus.wr_water_level), 128'(8192));
                chk("rl_at_8192", 128'(bus.rd_water_level), 128'(1024));
                chk("ae_when_full", 128'(bus.almost_empty), 128'(0));
            end
            if (i == 8193) chk("wl_after_drop", 128'(bus.wr_water_level), 128'(8192));
        end

        // Drain all 1024 read words.
        for (int i = 1; i <= 1024; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            if (i == LAT) chk("first_rd_word", bus.rd_data, 128'hFFF8FFF9FFFAFFFBFFFCFFFDFFFEFFFF);
            if (i == 1019) chk("ae_at_level5", 128'(bus.almost_empty), 128'(0));
            if (i == 1020) chk("ae_at_level4", 128'(bus.almost_empty), 128'(1));
        end
        chk("empty_after_drain", 128'(bus.rd_empty), 128'(1));
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        last = bus.rd_data;
        chk("last_rd_word", last, 128'hE000E001E002E003E004E005E006E007);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("read_when_empty_holds", bus.rd_data, last);

        // Partial group and simultaneous access from a clean state.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].re, 1'b0);
            chk($sformatf("vec%0d", i),
                128'({bus.wr_water_level, bus.rd_water_level, bus.rd_empty, bus.almost_empty}),
                128'({vecs[i].wl, vecs[i].rl, vecs[i].empty, vecs[i].ae}));
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("second_tbl_word", bus.rd_data, 128'h100F100E100D100C100B100A10091008);

        // Reset in the middle of a fill, with a write request during reset.
        for (int i = 0; i < 100; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        check_reset_values("midrst");
        for (int i = 0; i < 8; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("post_reset_word", bus.rd_data, 128'h70077006700570047003700270017000);
        chk("post_reset_empty", 128'(bus.rd_empty), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
